// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the two-port DMEM arbiter.
// Also holds the address range helper used by the top.
package dmem_arb_pkg;

    localparam int unsigned MEM_BYTES_DEF  = 32'd4096;
    localparam int unsigned WAIT_LIMIT_DEF = 32'd4;
    localparam int unsigned LOCK_MAX_DEF   = 32'd8;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_M0   = 2'd1,
        SEL_M1   = 2'd2
    } port_sel_e;

    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] limit);
        return (addr < limit);
    endfunction

endpackage

// File: rtl/dmem_arb_resp.sv
// Per-port response register: a grant turns into a one-cycle rvalid pulse
// with read data (reads in range only) and an out-of-range error flag.
module dmem_arb_resp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gnt_i,
    input  logic        we_i,
    input  logic        in_range_i,
    input  logic [31:0] read_data_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    // Next response: data only for in-range reads, zero otherwise
    always_comb begin
        rvalid_d = gnt_i;
        err_d    = 1'b0;
        rdata_d  = 32'h0000_0000;
        if (gnt_i) begin
            err_d = ~in_range_i;
            if (!we_i && in_range_i) begin
                rdata_d = read_data_i;
            end else begin
                rdata_d = 32'h0000_0000;
            end
        end else begin
            err_d   = 1'b0;
            rdata_d = 32'h0000_0000;
        end
    end

    // Response register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0000_0000;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port DMEM between the CPU (m0) and a burst loader (m1),
// with starvation protection and a bounded lock tenure for m1.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = MEM_BYTES_DEF,
    parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEF,
    parameter int unsigned LOCK_MAX   = LOCK_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    input  logic        m1_lock,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_write_data,
    output logic        dmem_MemRW,
    input  logic [31:0] dmem_read_data
);

    localparam int unsigned SW = $clog2(WAIT_LIMIT + 1);
    localparam int unsigned LW = $clog2(LOCK_MAX + 1);
    localparam logic [31:0]   MEM_LIMIT_C  = 32'(MEM_BYTES);
    localparam logic [SW-1:0] WAIT_LIM_C   = SW'(WAIT_LIMIT);
    localparam logic [LW-1:0] LOCK_LIM_C   = LW'(LOCK_MAX);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    port_sel_e     sel_s;
    logic          m0_in_range_s;
    logic          m1_in_range_s;

    assign m0_in_range_s = addr_in_range(m0_addr, MEM_LIMIT_C);
    assign m1_in_range_s = addr_in_range(m1_addr, MEM_LIMIT_C);

    // Grant selection: m0 has priority in ARB unless m1 has waited too long
    always_comb begin
        sel_s = SEL_NONE;
        case (state_q)
            ARB: begin
                if (m0_req && m1_req) begin
                    if (starve_cnt_q >= WAIT_LIM_C) begin
                        sel_s = SEL_M1;
                    end else begin
                        sel_s = SEL_M0;
                    end
                end else if (m0_req) begin
                    sel_s = SEL_M0;
                end else if (m1_req) begin
                    sel_s = SEL_M1;
                end else begin
                    sel_s = SEL_NONE;
                end
            end
            LOCK1: begin
                if (m1_req) begin
                    sel_s = SEL_M1;
                end else begin
                    sel_s = SEL_NONE;
                end
            end
            default: sel_s = SEL_NONE;
        endcase
    end

    // Next state, starvation counter and lock tenure counter
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        lock_cnt_d   = lock_cnt_q;

        if (m1_req && (sel_s != SEL_M1)) begin
            if (starve_cnt_q >= WAIT_LIM_C) begin
                starve_cnt_d = WAIT_LIM_C;
            end else begin
                starve_cnt_d = starve_cnt_q + SW'(1);
            end
        end else begin
            starve_cnt_d = '0;
        end

        case (state_q)
            ARB: begin
                if ((sel_s == SEL_M1) && m1_lock) begin
                    state_d    = LOCK1;
                    lock_cnt_d = LW'(1);
                end else begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end
            end
            LOCK1: begin
                // The access carrying lock=0 is the last one of the tenure
                if (!m1_lock || ((sel_s == SEL_M1) && ((lock_cnt_q + LW'(1)) >= LOCK_LIM_C))) begin
                    state_d      = ARB;
                    lock_cnt_d   = '0;
                    starve_cnt_d = '0;
                end else if (sel_s == SEL_M1) begin
                    state_d    = LOCK1;
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end else begin
                    state_d    = LOCK1;
                    lock_cnt_d = lock_cnt_q;
                end
            end
            default: begin
                state_d      = ARB;
                lock_cnt_d   = '0;
                starve_cnt_d = '0;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB;
            starve_cnt_q <= '0;
            lock_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    // DMEM mux; out-of-range writes are suppressed at MemRW
    always_comb begin
        m0_gnt          = 1'b0;
        m1_gnt          = 1'b0;
        dmem_address    = 32'h0000_0000;
        dmem_write_data = 32'h0000_0000;
        dmem_MemRW      = 1'b0;
        case (sel_s)
            SEL_M0: begin
                m0_gnt          = 1'b1;
                dmem_address    = m0_addr;
                dmem_write_data = m0_wdata;
                dmem_MemRW      = m0_we & m0_in_range_s;
            end
            SEL_M1: begin
                m1_gnt          = 1'b1;
                dmem_address    = m1_addr;
                dmem_write_data = m1_wdata;
                dmem_MemRW      = m1_we & m1_in_range_s;
            end
            default: begin
                m0_gnt          = 1'b0;
                m1_gnt          = 1'b0;
                dmem_address    = 32'h0000_0000;
                dmem_write_data = 32'h0000_0000;
                dmem_MemRW      = 1'b0;
            end
        endcase
    end

    dmem_arb_resp u_m0_resp (
        .clk         (clk),
        .rst_n       (rst_n),
        .gnt_i       (m0_gnt),
        .we_i        (m0_we),
        .in_range_i  (m0_in_range_s),
        .read_data_i (dmem_read_data),
        .rvalid_o    (m0_rvalid),
        .rdata_o     (m0_rdata),
        .err_o       (m0_err)
    );

    dmem_arb_resp u_m1_resp (
        .clk         (clk),
        .rst_n       (rst_n),
        .gnt_i       (m1_gnt),
        .we_i        (m1_we),
        .in_range_i  (m1_in_range_s),
        .read_data_i (dmem_read_data),
        .rvalid_o    (m1_rvalid),
        .rdata_o     (m1_rdata),
        .err_o       (m1_err)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for per-cycle grants and
// responses, plus hand sequences for idle-in-lock and mid-access reset.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] dmem_address, dmem_write_data, dmem_read_data;
    logic        dmem_MemRW;

    logic [31:0] mem [0:1023];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .m1_lock(m1_lock),
        .dmem_address(dmem_address), .dmem_write_data(dmem_write_data),
        .dmem_MemRW(dmem_MemRW), .dmem_read_data(dmem_read_data)
    );

    // Behavioural DMEM: combinational read, write on the rising edge
    assign dmem_read_data = mem[dmem_address[11:2]];
    always @(posedge clk) begin
        if (dmem_MemRW) mem[dmem_address[11:2]] <= dmem_write_data;
    end

    typedef struct packed {
        logic m0r; logic m0w; logic [31:0] m0a; logic [31:0] m0d;
        logic m1r; logic m1w; logic m1l; logic [31:0] m1a; logic [31:0] m1d;
        logic g0; logic g1; logic mrw; logic [31:0] ea; logic [31:0] ew;
        logic rv0; logic er0; logic [31:0] rd0;
        logic rv1; logic er1; logic [31:0] rd1;
    } vec_t;

    localparam int NV = 40;
    vec_t vecs [0:NV-1];

    localparam logic [31:0] Z  = 32'h0000_0000;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] A5 = 32'hA5A5_A5A5;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic m0r, input logic m0w, input logic [31:0] m0a, input logic [31:0] m0d,
                          input logic m1r, input logic m1w, input logic m1l, input logic [31:0] m1a,
                          input logic [31:0] m1d);
        m0_req = m0r; m0_we = m0w; m0_addr = m0a; m0_wdata = m0d;
        m1_req = m1r; m1_we = m1w; m1_lock = m1l; m1_addr = m1a; m1_wdata = m1d;
    endtask

    task automatic chk_idle_resp(input string tag);
        chk1({tag, " m0_rvalid"}, m0_rvalid, 1'b0);
        chk1({tag, " m1_rvalid"}, m1_rvalid, 1'b0);
        chk32({tag, " m0_rdata"}, m0_rdata, Z);
        chk32({tag, " m1_rdata"}, m1_rdata, Z);
        chk1({tag, " m0_err"}, m0_err, 1'b0);
        chk1({tag, " m1_err"}, m1_err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // m0 fields | m1 fields (req,we,lock,addr,wdata) | gnt0,gnt1,MemRW,addr,wdata | m0 resp | m1 resp
        vecs[0]  = '{1'b1,1'b1,32'h10,DB, 1'b0,1'b0,1'b0,Z,Z, 1'b1,1'b0,1'b1,32'h10,DB, 1'b1,1'b0,Z, 1'b0,1'b0,Z};
        vecs[1]  = '{1'b1,1'b0,32'h10,Z,  1'b0,1'b0,1'b0,Z,Z, 1'b1,1'b0,1'b0,32'h10,Z,  1'b1,1'b0,DB, 1'b0,1'b0,Z};
        vecs[2]  = '{1'b0,1'b0,Z,Z,       1'b0,1'b0,1'b0,Z,Z, 1'b0,1'b0,1'b0,Z,Z,       1'b0,1'b0,Z, 1'b0,1'b0,Z};
        vecs[3]  = '{1'b0,1'b0,Z,Z, 1'b1,1'b1,1'b0,32'h1000,32'h55, 1'b0,1'b1,1'b0,32'h1000,32'h55, 1'b0,1'b0,Z, 1'b1,1'b1,Z};
        vecs[4]  = '{1'b0,1'b0,Z,Z, 1'b1,1'b0,1'b0,32'h1000,Z,      1'b0,1'b1,1'b0,32'h1000,Z,      1'b0,1'b0,Z, 1'b1,1'b1,Z};
        vecs[5]  = '{1'b0,1'b0,Z,Z, 1'b1,1'b1,1'b0,32'hFFC,32'h12345678, 1'b0,1'b1,1'b1,32'hFFC,32'h12345678, 1'b0,1'b0,Z, 1'b1,1'b0,Z};
        vecs[6]  = '{1'b0,1'b0,Z,Z, 1'b1,1'b0,1'b0,32'hFFC,Z, 1'b0,1'b1,1'b0,32'hFFC,Z, 1'b0,1'b0,Z, 1'b1,1'b0,32'h12345678};
        vecs[7]  = '{1'b1,1'b1,32'h22,A5, 1'b0,1'b0,1'b0,Z,Z, 1'b1,1'b0,1'b1,32'h22,A5, 1'b1,1'b0,Z, 1'b0,1'b0,Z};
        vecs[8]  = '{1'b1,1'b0,32'h20,Z, 1'b0,1'b0,1'b0,Z,Z, 1'b1,1'b0,1'b0,32'h20,Z, 1'b1,1'b0,A5, 1'b0,1'b0,Z};
        vecs[9]  = '{1'b1,1'b0,32'h21,Z, 1'b0,1'b0,1'b0,Z,Z, 1'b1,1'b0,1'b0,32'h21,Z, 1'b1,1'b0,A5, 1'b0,1'b0,Z};
        vecs[10] = '{1'b1,1'b0,32'h22,Z, 1'b0,1'b0,1'b0,Z,Z, 1'b1,1'b0,1'b0,32'h22,Z, 1'b1,1'b0,A5, 1'b0,1'b0,Z};
        vecs[11] = '{1'b1,1'b0,32'h23,Z, 1'b0,1'b0,1'b0,Z,Z, 1'b1,1'b0,1'b0,32'h23,Z, 1'b1,1'b0,A5, 1'b0,1'b0,Z};
        vecs[12] = '{1'b0,1'b0,Z,Z,       1'b0,1'b0,1'b0,Z,Z, 1'b0,1'b0,1'b0,Z,Z,       1'b0,1'b0,Z, 1'b0,1'b0,Z};
        // both read continuously: four m0 grants, then one m1 grant
        for (int k = 13; k <= 22; k++) begin
            if (k == 17 || k == 22)
                vecs[k] = '{1'b1,1'b0,32'h10,Z, 1'b1,1'b0,1'b0,32'h20,Z, 1'b0,1'b1,1'b0,32'h20,Z, 1'b0,1'b0,Z, 1'b1,1'b0,A5};
            else
                vecs[k] = '{1'b1,1'b0,32'h10,Z, 1'b1,1'b0,1'b0,32'h20,Z, 1'b1,1'b0,1'b0,32'h10,Z, 1'b1,1'b0,DB, 1'b0,1'b0,Z};
        end
        vecs[23] = '{1'b0,1'b0,Z,Z, 1'b0,1'b0,1'b0,Z,Z, 1'b0,1'b0,1'b0,Z,Z, 1'b0,1'b0,Z, 1'b0,1'b0,Z};
        // locked burst: eight m1 grants despite m0 requesting from the second beat
        for (int k = 0; k < 8; k++) begin
            vecs[24+k] = '{(k != 0),1'b0,32'h10,Z, 1'b1,1'b1,1'b1,32'h100 + 32'(4*k),32'h1000_0000 + 32'(k),
                           1'b0,1'b1,1'b1,32'h100 + 32'(4*k),32'h1000_0000 + 32'(k), 1'b0,1'b0,Z, 1'b1,1'b0,Z};
        end
        vecs[32] = '{1'b1,1'b0,32'h10,Z, 1'b1,1'b1,1'b1,32'h120,32'h1000_0008, 1'b1,1'b0,1'b0,32'h10,Z, 1'b1,1'b0,DB, 1'b0,1'b0,Z};
        vecs[33] = '{1'b0,1'b0,Z,Z, 1'b1,1'b1,1'b1,32'h120,32'h1000_0008, 1'b0,1'b1,1'b1,32'h120,32'h1000_0008, 1'b0,1'b0,Z, 1'b1,1'b0,Z};
        vecs[34] = '{1'b0,1'b0,Z,Z, 1'b1,1'b1,1'b1,32'h124,32'h1000_0009, 1'b0,1'b1,1'b1,32'h124,32'h1000_0009, 1'b0,1'b0,Z, 1'b1,1'b0,Z};
        vecs[35] = '{1'b1,1'b0,32'h100,Z, 1'b1,1'b1,1'b0,32'h128,32'h1000_000A, 1'b0,1'b1,1'b1,32'h128,32'h1000_000A, 1'b0,1'b0,Z, 1'b1,1'b0,Z};
        vecs[36] = '{1'b1,1'b0,32'h100,Z, 1'b1,1'b1,1'b1,32'h12C,32'h1000_000B, 1'b1,1'b0,1'b0,32'h100,Z, 1'b1,1'b0,32'h1000_0000, 1'b0,1'b0,Z};
        vecs[37] = '{1'b0,1'b0,Z,Z, 1'b1,1'b1,1'b0,32'h12C,32'h1000_000B, 1'b0,1'b1,1'b1,32'h12C,32'h1000_000B, 1'b0,1'b0,Z, 1'b1,1'b0,Z};
        vecs[38] = '{1'b1,1'b0,32'h12C,Z, 1'b0,1'b0,1'b0,Z,Z, 1'b1,1'b0,1'b0,32'h12C,Z, 1'b1,1'b0,32'h1000_000B, 1'b0,1'b0,Z};
        vecs[39] = '{1'b1,1'b0,32'h11C,Z, 1'b0,1'b0,1'b0,Z,Z, 1'b1,1'b0,1'b0,32'h11C,Z, 1'b1,1'b0,32'h1000_0007, 1'b0,1'b0,Z};

        rst_n = 1'b0;
        set_in(1'b0,1'b0,Z,Z, 1'b0,1'b0,1'b0,Z,Z);
        repeat (2) @(posedge clk);
        #1;
        chk_idle_resp("reset");
        chk1("reset m0_gnt", m0_gnt, 1'b0);
        chk1("reset MemRW", dmem_MemRW, 1'b0);
        chk32("reset dmem_address", dmem_address, Z);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].m0r, vecs[i].m0w, vecs[i].m0a, vecs[i].m0d,
                   vecs[i].m1r, vecs[i].m1w, vecs[i].m1l, vecs[i].m1a, vecs[i].m1d);
            #1;
            chk1($sformatf("v%0d m0_gnt", i), m0_gnt, vecs[i].g0);
            chk1($sformatf("v%0d m1_gnt", i), m1_gnt, vecs[i].g1);
            chk1($sformatf("v%0d MemRW", i), dmem_MemRW, vecs[i].mrw);
            chk32($sformatf("v%0d dmem_address", i), dmem_address, vecs[i].ea);
            chk32($sformatf("v%0d dmem_write_data", i), dmem_write_data, vecs[i].ew);
            @(negedge clk);
            chk1($sformatf("v%0d m0_rvalid", i), m0_rvalid, vecs[i].rv0);
            chk1($sformatf("v%0d m0_err", i), m0_err, vecs[i].er0);
            chk32($sformatf("v%0d m0_rdata", i), m0_rdata, vecs[i].rd0);
            chk1($sformatf("v%0d m1_rvalid", i), m1_rvalid, vecs[i].rv1);
            chk1($sformatf("v%0d m1_err", i), m1_err, vecs[i].er1);
            chk32($sformatf("v%0d m1_rdata", i), m1_rdata, vecs[i].rd1);
        end

        // Idle m1 inside a lock tenure keeps m0 out
        set_in(1'b0,1'b0,Z,Z, 1'b1,1'b1,1'b1,32'h200,32'h77);
        #1 chk1("lockidle enter m1_gnt", m1_gnt, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            set_in(1'b1,1'b0,32'h10,Z, 1'b0,1'b0,1'b1,Z,Z);
            #1;
            chk1($sformatf("lockidle%0d m0_gnt", k), m0_gnt, 1'b0);
            chk1($sformatf("lockidle%0d m1_gnt", k), m1_gnt, 1'b0);
            @(negedge clk);
        end
        set_in(1'b1,1'b0,32'h10,Z, 1'b1,1'b1,1'b0,32'h204,32'h88);
        #1;
        chk1("lockidle last m1_gnt", m1_gnt, 1'b1);
        chk1("lockidle last m0_gnt", m0_gnt, 1'b0);
        @(negedge clk);
        set_in(1'b1,1'b0,32'h200,Z, 1'b0,1'b0,1'b0,Z,Z);
        #1 chk1("lockidle exit m0_gnt", m0_gnt, 1'b1);
        @(negedge clk);
        chk32("lockidle exit m0_rdata", m0_rdata, 32'h77);

        // Reset asserted while a read response is pending
        set_in(1'b1,1'b0,32'h204,Z, 1'b0,1'b0,1'b0,Z,Z);
        #1 chk1("rst pending m0_gnt", m0_gnt, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_idle_resp("rst async");
        set_in(1'b0,1'b0,Z,Z, 1'b0,1'b0,1'b0,Z,Z);
        @(posedge clk);
        #1 chk_idle_resp("rst held");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_resp("rst release1");
        @(negedge clk);
        chk_idle_resp("rst release2");
        set_in(1'b1,1'b0,32'h204,Z, 1'b0,1'b0,1'b0,Z,Z);
        @(negedge clk);
        chk1("post-rst m0_rvalid", m0_rvalid, 1'b1);
        chk32("post-rst m0_rdata", m0_rdata, 32'h88);
        set_in(1'b0,1'b0,Z,Z, 1'b0,1'b0,1'b0,Z,Z);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (DMEM) between two requesters.
  - m0: the CPU load/store unit.
  - m1: a debug/program loader that writes memory images in bursts.
- Sits between the requesters and DMEM and drives DMEM's address, write_data and MemRW.
- Provides a req/gnt handshake, registered read responses, range checking, starvation protection for m1 and a bounded lock for m1 bursts.

Parameters:
- MEM_BYTES, 4096, DMEM size in bytes; addresses >= MEM_BYTES are out of range.
- WAIT_LIMIT, 4, consecutive denied m1 cycles after which m1 beats m0.
- LOCK_MAX, 8, maximum m1 grants per lock tenure.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  m0 request; m0_we/m0_addr/m0_wdata held stable until m0_gnt
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  32  byte address, word-aligned
- m0_wdata  in  32  write data
- m0_gnt  out  1  combinational grant; the access completes at the rising edge ending this cycle
- m0_rvalid  out  1  response valid, one-cycle pulse
- m0_rdata  out  32  registered read data
- m0_err  out  1  out-of-range flag, qualified by m0_rvalid
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err  same as m0
- m1_lock  in  1  m1 requests to keep ownership across consecutive accesses
- dmem_address  out  32  to DMEM address
- dmem_write_data  out  32  to DMEM write_data
- dmem_MemRW  out  1  to DMEM MemRW
- dmem_read_data  in  32  from DMEM read_data (combinational read)

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst_n is asynchronous, active-low.
  - While rst_n = 0: state = ARB, starve_cnt = 0, lock_cnt = 0; all rvalid/err = 0; all rdata = 0.
  - Reset mid-operation drops any pending response; no rvalid follows reset release.
- Mux:
  - dmem_address and dmem_write_data follow the granted port.
  - With no grant, both are 0 and dmem_MemRW = 0.
  - dmem_MemRW = granted_we AND in_range.
- Range check:
  - in_range = addr < MEM_BYTES.
  - If out of range: write suppressed, rdata = 0, err = 1 with rvalid.
- Responses:
  - Every grant produces rvalid on the granting port exactly one cycle later, for writes too.
  - Reads: rdata = dmem_read_data sampled at the grant edge.
  - Writes: rdata = 0.
- State ARB:
  - Only one requester: it is granted.
  - Both requesting: m0 wins unless starve_cnt >= WAIT_LIMIT, in which case m1 wins.
  - starve_cnt increments when m1_req = 1 and m1 is not granted (saturates at WAIT_LIMIT).
  - starve_cnt clears on an m1 grant or when m1_req = 0.
  - m1 granted with m1_lock = 1: go to LOCK1, lock_cnt = 1.
- State LOCK1:
  - m0_gnt = 0.
  - m1 is granted whenever m1_req = 1; each grant increments lock_cnt.
  - Exit to ARB when m1_lock = 0, or on the cycle lock_cnt reaches LOCK_MAX.
  - On any exit, starve_cnt = 0, so a requesting m0 wins the next cycle.
  - An idle m1 (req = 0, lock = 1) holds LOCK1 but does not count.
- Latency: grant is 0 cycles after req when uncontended; response is 1 cycle after grant.
- Throughput: one access per cycle, back-to-back.
- Misaligned address: addr[1:0] is ignored, and the word at addr[11:2] is accessed, matching DMEM indexing; no error is raised.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (ARB, LOCK1);
  - default constants MEM_BYTES, WAIT_LIMIT, LOCK_MAX;
  - a port-select encoding (SEL_NONE, SEL_M0, SEL_M1).
- One sub-module, dmem_arb_resp, instantiated per port. It holds the response register (rvalid/rdata/err) and takes as inputs:
  - the grant;
  - the write enable;
  - the in-range flag;
  - dmem_read_data.

Test Plan:
- Reset/basic:
  - Assert rst_n = 0 mid-read with rvalid pending, then release -> all outputs 0; no rvalid after release.
  - m0 writes 0xDEADBEEF @ 0x10; next cycle m0 reads 0x10 -> m0_gnt same cycle each time; m0_rvalid one cycle later; m0_rdata = 0xDEADBEEF; m0_err = 0.
- Contention:
  - m0 and m1 both read continuously -> m0 granted cycles 0-3, m1 granted cycle 4; then m0 again for 4 cycles; pattern repeats.
- Lock:
  - m1_lock = 1 with 12 back-to-back writes to 0x100..0x12C while m0_req = 1 -> m1 gets 8 grants, then m0 granted once, then m1 resumes.
  - In the same run, with m1_lock dropped after 3 writes -> exit after 3 grants; m0 granted the next cycle.
- Range:
  - m1 writes 0x55 @ 0x1000 -> dmem_MemRW = 0; m1_err = 1 with m1_rvalid.
  - Read of 0x1000 -> m1_rdata = 0; m1_err = 1.
- Alignment/throughput:
  - m0 writes 0xA5A5A5A5 @ 0x22, then 4 reads at 0x20, 0x21, 0x22, 0x23 on consecutive cycles -> all return 0xA5A5A5A5; rvalid high 4 consecutive cycles.
